// File: rtl/craft_round_controller.sv
// Control sequencer for the nibble-serial CRAFT datapath: LOAD, NUM_ROUNDS x NIBBLES round cycles, NIBBLES output cycles, done pulse.
// All strobes are registered and decoded from next state, so there is no combinational path from start/abort to any output.
module craft_round_controller #(
  parameter int NUM_ROUNDS = 32,
  parameter int NIBBLES    = 16,
  parameter int RW         = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       ce,
  output logic                       cs0,
  output logic                       cs1,
  output logic                       cm0,
  output logic                       cm1,
  output logic                       ck_en,
  output logic                       ck0,
  output logic                       sb_en,
  output logic [RW-1:0]              round,
  output logic [$clog2(NIBBLES)-1:0] cnt,
  output logic                       out_valid
);

  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(NIBBLES / 2);
  localparam logic [CW-1:0] CNT_QTR  = CW'(NIBBLES / 4);
  localparam logic [RW-1:0] RND_LAST = RW'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic ce;
    logic cs0;
    logic cs1;
    logic cm0;
    logic cm1;
    logic ck_en;
    logic ck0;
    logic sb_en;
    logic out_valid;
  } ctrl_t;

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          busy_now;

  assign busy_now = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_OUT);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        round_d = '0;
        cnt_d   = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ROUND;
        round_d = '0;
        cnt_d   = '0;
      end
      S_ROUND: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // The final round hands over to OUT with the round index frozen.
          if (round_q == RND_LAST) state_d = S_OUT;
          else                     round_d = round_q + RW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          round_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        round_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
        cnt_d   = '0;
      end
    endcase
    if (abort && busy_now) begin
      state_d = S_IDLE;
      round_d = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_LOAD: begin
        ctrl_d.busy  = 1'b1;
        ctrl_d.ce    = 1'b1;
        ctrl_d.cs0   = 1'b1;
        ctrl_d.ck_en = 1'b1;
        ctrl_d.ck0   = 1'b1;
      end
      S_ROUND: begin
        ctrl_d.busy  = 1'b1;
        ctrl_d.ce    = 1'b1;
        ctrl_d.ck_en = 1'b1;
        ctrl_d.cm1   = (cnt_d < CNT_HALF);
        ctrl_d.cm0   = (cnt_d < CNT_QTR);
        ctrl_d.sb_en = (round_d != RND_LAST);
        ctrl_d.cs1   = (cnt_d == CNT_LAST) && (round_d != RND_LAST);
      end
      S_OUT: begin
        ctrl_d.busy      = 1'b1;
        ctrl_d.ce        = 1'b1;
        ctrl_d.out_valid = 1'b1;
      end
      S_DONE: ctrl_d.done = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign ce        = ctrl_q.ce;
  assign cs0       = ctrl_q.cs0;
  assign cs1       = ctrl_q.cs1;
  assign cm0       = ctrl_q.cm0;
  assign cm1       = ctrl_q.cm1;
  assign ck_en     = ctrl_q.ck_en;
  assign ck0       = ctrl_q.ck0;
  assign sb_en     = ctrl_q.sb_en;
  assign out_valid = ctrl_q.out_valid;
  assign round     = round_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_craft_round_controller.sv
// Bench for craft_round_controller: checkpoint table plus per-cycle expectations over a full run,
// followed by reset, abort and back-to-back sequences.
module tb_craft_round_controller;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       busy, done, ce, cs0, cs1, cm0, cm1, ck_en, ck0, sb_en, out_valid;
  logic [7:0] round;
  logic [3:0] cnt;

  craft_round_controller #(.NUM_ROUNDS(32), .NIBBLES(16), .RW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .ce(ce), .cs0(cs0), .cs1(cs1), .cm0(cm0), .cm1(cm1),
    .ck_en(ck_en), .ck0(ck0), .sb_en(sb_en), .round(round), .cnt(cnt), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, done, ce, cs0, cs1, cm0, cm1, ck_en, ck0, sb_en, out_valid;
    logic [7:0] round;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    int    cyc;
    string name;
    obs_t  exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vt[$];

  function automatic obs_t mk(input logic b, d, e, s0, s1, m0, m1, ke, k0, sb, ov,
                              input int r, input int c);
    obs_t o;
    o.busy = b; o.done = d; o.ce = e; o.cs0 = s0; o.cs1 = s1; o.cm0 = m0; o.cm1 = m1;
    o.ck_en = ke; o.ck0 = k0; o.sb_en = sb; o.out_valid = ov;
    o.round = 8'(r); o.cnt = 4'(c);
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(busy, done, ce, cs0, cs1, cm0, cm1, ck_en, ck0, sb_en, out_valid,
              int'(round), int'(cnt));
  endfunction

  // Expected outputs k cycles after the edge that sampled start (k=1 is LOAD).
  function automatic obs_t exp_at(input int k);
    int j, r, c;
    obs_t o;
    o = '0;
    if (k == 1) begin
      o = mk(1,0,1,1,0,0,0,1,1,0,0, 0, 0);
    end else if (k >= 2 && k <= 513) begin
      j = k - 2; r = j / 16; c = j % 16;
      o = mk(1, 0, 1, 0, (c == 15) && (r != 31), c < 4, c < 8, 1, 0, r != 31, 0, r, c);
    end else if (k >= 514 && k <= 529) begin
      o = mk(1,0,1,0,0,0,0,0,0,0,1, 31, k - 514);
    end else if (k == 530) begin
      o = mk(0,1,0,0,0,0,0,0,0,0,0, 0, 0);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t s;
    int   ov_cnt, dn_cnt, done_k;
    int   dq[$];

    //              busy done ce cs0 cs1 cm0 cm1 cken ck0 sb ov  rnd cnt
    vt.push_back('{1,   "load",        mk(1,0,1,1,0,0,0,1,1,0,0,  0,  0)});
    vt.push_back('{2,   "r0_c0",       mk(1,0,1,0,0,1,1,1,0,1,0,  0,  0)});
    vt.push_back('{5,   "r0_c3",       mk(1,0,1,0,0,1,1,1,0,1,0,  0,  3)});
    vt.push_back('{6,   "r0_c4",       mk(1,0,1,0,0,0,1,1,0,1,0,  0,  4)});
    vt.push_back('{9,   "r0_c7",       mk(1,0,1,0,0,0,1,1,0,1,0,  0,  7)});
    vt.push_back('{10,  "r0_c8",       mk(1,0,1,0,0,0,0,1,0,1,0,  0,  8)});
    vt.push_back('{17,  "r0_c15",      mk(1,0,1,0,1,0,0,1,0,1,0,  0, 15)});
    vt.push_back('{18,  "r1_c0",       mk(1,0,1,0,0,1,1,1,0,1,0,  1,  0)});
    vt.push_back('{50,  "r3_c0",       mk(1,0,1,0,0,1,1,1,0,1,0,  3,  0)});
    vt.push_back('{57,  "r3_c7",       mk(1,0,1,0,0,0,1,1,0,1,0,  3,  7)});
    vt.push_back('{65,  "r3_c15",      mk(1,0,1,0,1,0,0,1,0,1,0,  3, 15)});
    vt.push_back('{482, "r30_c0",      mk(1,0,1,0,0,1,1,1,0,1,0, 30,  0)});
    vt.push_back('{497, "r30_c15",     mk(1,0,1,0,1,0,0,1,0,1,0, 30, 15)});
    vt.push_back('{498, "r31_c0",      mk(1,0,1,0,0,1,1,1,0,0,0, 31,  0)});
    vt.push_back('{513, "r31_c15",     mk(1,0,1,0,0,0,0,1,0,0,0, 31, 15)});
    vt.push_back('{514, "out_c0",      mk(1,0,1,0,0,0,0,0,0,0,1, 31,  0)});
    vt.push_back('{529, "out_c15",     mk(1,0,1,0,0,0,0,0,0,0,1, 31, 15)});
    vt.push_back('{530, "done",        mk(0,1,0,0,0,0,0,0,0,0,0,  0,  0)});
    vt.push_back('{531, "idle_after",  mk(0,0,0,0,0,0,0,0,0,0,0,  0,  0)});

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", sample(), '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_after_release", sample(), '0);

    // Full run with start pulses while busy (cycle 100) and in DONE (cycle 530).
    start = 1'b1;
    tick();
    start = 1'b0;
    ov_cnt = 0; dn_cnt = 0;
    for (int k = 1; k <= 533; k++) begin
      s = sample();
      chk($sformatf("run_k%0d", k), s, exp_at(k));
      for (int i = 0; i < vt.size(); i++)
        if (vt[i].cyc == k) chk(vt[i].name, s, vt[i].exp);
      if (s.out_valid) ov_cnt++;
      if (s.done) dn_cnt++;
      start = (k == 100) || (k == 530);
      tick();
    end
    start = 1'b0;
    chk_int("out_valid_cycles", ov_cnt, 16);
    chk_int("done_pulses", dn_cnt, 1);

    // Asynchronous reset in round 5.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (84) tick();
    chk_int("pre_reset_round", int'(round), 5);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_round", sample(), '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_after_mid_reset", sample(), '0);
    tick();
    chk("idle_after_mid_reset2", sample(), '0);

    // Abort in LOAD.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_before_abort", sample(), exp_at(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_load", sample(), '0);
    tick();

    // Abort at cycle 200 (with start also high), restart at 205, done expected at 735.
    start = 1'b1;
    tick();
    start = 1'b0;
    dn_cnt = 0;
    for (int k = 1; k < 200; k++) begin
      if (done) dn_cnt++;
      tick();
    end
    chk("pre_abort_k200", sample(), exp_at(200));
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_idle_k201", sample(), '0);
    for (int k = 201; k < 205; k++) begin
      if (done) dn_cnt++;
      tick();
    end
    chk("idle_k205", sample(), '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_load_k206", sample(), exp_at(1));
    done_k = -1;
    for (int k = 206; k <= 800; k++) begin
      if (done) begin
        dn_cnt++;
        if (done_k < 0) done_k = k;
      end
      tick();
    end
    chk_int("abort_restart_done_cycle", done_k, 735);
    chk_int("abort_done_pulses", dn_cnt, 1);

    // Back-to-back with start held high.
    start = 1'b1;
    tick();
    for (int k = 1; k <= 1600; k++) begin
      if (done) dq.push_back(k);
      if (k == 531) chk("b2b_idle_gap", sample(), '0);
      if (k == 532) chk("b2b_second_load", sample(), exp_at(1));
      tick();
    end
    start = 1'b0;
    chk_int("b2b_done_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk_int("b2b_done1", dq[0], 530);
      chk_int("b2b_done2", dq[1], 1061);
      chk_int("b2b_done3", dq[2], 1592);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
